solve_ctrl: RTL and testbench

SOLVE_CTRL -- requirements
Module: solve_ctrl

---
 rtl/solve_pkg.sv | 19 +
 rtl/best_tracker.sv | 29 ++
 rtl/solve_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_solve_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solve_pkg.sv
// Shared widths, FSM state encoding and handshake cycle counts for the solve controller.
package solve_pkg;
    localparam int NUM_ROW      = 8;
    localparam int ENERGY_WIDTH = 15;
    localparam int DATA_WIDTH   = 8;

    localparam int POLL_CYCLES    = 3;
    localparam int ACK_MIN_CYCLES = 3;
    localparam int ACK_CAP_CYCLE  = 1;  // zero-based: second ACK cycle
    localparam int RELEASE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, CAL, POLL, ACK, RELEASE, REPORT
    } state_e;

    typedef logic signed [ENERGY_WIDTH:0] energy_t;

    localparam energy_t ENERGY_MAX = {1'b0, {ENERGY_WIDTH{1'b1}}};
endpackage

// File: rtl/best_tracker.sv
// Running best-of-trials register: keeps the lowest signed energy seen, earlier trial wins ties.
module best_tracker
    import solve_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               cap_i,
    input  logic [NUM_ROW-1:0] spin_i,
    input  energy_t            energy_i,
    output logic [NUM_ROW-1:0] best_spin_o,
    output energy_t            best_energy_o
);
    logic [NUM_ROW-1:0] spin_q;
    energy_t            energy_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            spin_q   <= '0;
            energy_q <= ENERGY_MAX;
        end else if (cap_i && (energy_i < energy_q)) begin
            spin_q   <= spin_i;
            energy_q <= energy_i;
        end
    end

    assign best_spin_o   = spin_q;
    assign best_energy_o = energy_q;
endmodule

// File: rtl/solve_ctrl.sv
// Solve sequencer: sample request, comparator handshake, best-of-trials report.
// Optional SOLVE_TIMEOUT_EN adds a 16-bit watchdog on WAIT/ACK that aborts with err.
module solve_ctrl
    import solve_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] max_fails_cfg,
    input  logic [7:0]            num_trials,
    output logic                  sample_req,
    input  logic                  sample_vld,
    input  logic [NUM_ROW-1:0]    sample_spin,
    input  energy_t               sample_energy,
    output energy_t               hamiltonian_energy,
    output logic [NUM_ROW-1:0]    save_spin_array,
    output logic [DATA_WIDTH-1:0] max_fails,
    output logic                  cal_done,
    output logic                  done_ack,
    input  logic                  done,
    input  logic [NUM_ROW-1:0]    best_spin,
    input  energy_t               best_hamiltonian,
    output logic [NUM_ROW-1:0]    result_spin,
    output energy_t               result_energy,
    output logic                  result_vld,
    output logic                  busy,
    output logic                  err
);
    localparam logic [1:0] POLL_LAST = 2'(POLL_CYCLES - 1);
    localparam logic [1:0] ACK_LAST  = 2'(ACK_MIN_CYCLES - 1);
    localparam logic [1:0] ACK_CAP   = 2'(ACK_CAP_CYCLE);
    localparam logic [1:0] REL_LAST  = 2'(RELEASE_CYCLES - 1);

    state_e                state_q;
    logic [1:0]            phase_q;
    logic [7:0]            trial_cnt_q, trial_lim_q, trial_cnt_d;
    energy_t               ham_q, res_energy_q;
    logic [NUM_ROW-1:0]    spin_q, res_spin_q;
    logic [DATA_WIDTH-1:0] max_fails_q;
    logic                  sample_req_q, cal_done_q, done_ack_q, busy_q, err_q, result_vld_q;
    logic                  cfg_ok, trk_clear, trk_cap, wdog_hit;
    logic [NUM_ROW-1:0]    run_spin;
    energy_t               run_energy;

    assign cfg_ok      = (max_fails_cfg != '0) && (num_trials != 8'd0);
    assign trk_clear   = (state_q == IDLE) && start && cfg_ok;
    assign trk_cap     = (state_q == ACK) && (phase_q == ACK_CAP);
    assign trial_cnt_d = trial_cnt_q + 8'd1;

`ifdef SOLVE_TIMEOUT_EN
    logic [15:0] wdog_q;

    // Restarts on every entry to WAIT or ACK; the 65535th cycle there aborts.
    always_ff @(posedge clk) begin
        if (reset || !((state_q == WAIT) || (state_q == ACK))) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    assign wdog_hit = (wdog_q == 16'hFFFE);
`else
    assign wdog_hit = 1'b0;
`endif

    best_tracker u_best (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (trk_clear),
        .cap_i        (trk_cap),
        .spin_i       (best_spin),
        .energy_i     (best_hamiltonian),
        .best_spin_o  (run_spin),
        .best_energy_o(run_energy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            trial_cnt_q  <= '0;
            trial_lim_q  <= '0;
            ham_q        <= '0;
            spin_q       <= '0;
            max_fails_q  <= '0;
            res_spin_q   <= '0;
            res_energy_q <= '0;
            sample_req_q <= 1'b0;
            cal_done_q   <= 1'b0;
            done_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            result_vld_q <= 1'b0;
        end else begin
            sample_req_q <= 1'b0;
            cal_done_q   <= 1'b0;
            err_q        <= 1'b0;
            result_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && cfg_ok) begin
                        max_fails_q  <= max_fails_cfg;
                        trial_lim_q  <= num_trials;
                        trial_cnt_q  <= '0;
                        busy_q       <= 1'b1;
                        sample_req_q <= 1'b1;
                        state_q      <= REQ;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                REQ: state_q <= WAIT;
                WAIT: begin
                    if (wdog_hit) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sample_vld) begin
                        ham_q      <= sample_energy;
                        spin_q     <= sample_spin;
                        cal_done_q <= 1'b1;
                        state_q    <= CAL;
                    end
                end
                CAL: begin
                    phase_q <= '0;
                    state_q <= POLL;
                end
                POLL: begin
                    if (done) begin
                        done_ack_q <= 1'b1;
                        phase_q    <= '0;
                        state_q    <= ACK;
                    end else if (phase_q == POLL_LAST) begin
                        sample_req_q <= 1'b1;
                        state_q      <= REQ;
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                // phase_q saturates at ACK_LAST while the comparator keeps done high
                ACK: begin
                    if (wdog_hit) begin
                        done_ack_q <= 1'b0;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if ((phase_q == ACK_LAST) && !done) begin
                        done_ack_q <= 1'b0;
                        phase_q    <= '0;
                        state_q    <= RELEASE;
                    end else if (phase_q != ACK_LAST) begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                RELEASE: begin
                    if (phase_q == REL_LAST) begin
                        trial_cnt_q <= trial_cnt_d;
                        if (trial_cnt_d == trial_lim_q) begin
                            res_spin_q   <= run_spin;
                            res_energy_q <= run_energy;
                            result_vld_q <= 1'b1;
                            state_q      <= REPORT;
                        end else begin
                            sample_req_q <= 1'b1;
                            state_q      <= REQ;
                        end
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_req         = sample_req_q;
    assign cal_done           = cal_done_q;
    assign done_ack           = done_ack_q;
    assign busy               = busy_q;
    assign err                = err_q;
    assign result_vld         = result_vld_q;
    assign hamiltonian_energy = ham_q;
    assign save_spin_array    = spin_q;
    assign max_fails          = max_fails_q;
    assign result_spin        = res_spin_q;
    assign result_energy      = res_energy_q;
endmodule

// File: tb/tb_solve_ctrl.sv
// Directed bench for solve_ctrl: vector table of whole solves plus hand sequences for corners.
`timescale 1ns/1ps
module tb_solve_ctrl;
    import solve_pkg::*;

    logic                  clk;
    logic                  reset, start;
    logic [DATA_WIDTH-1:0] max_fails_cfg;
    logic [7:0]            num_trials;
    logic                  sample_req, sample_vld;
    logic [NUM_ROW-1:0]    sample_spin;
    energy_t               sample_energy;
    energy_t               hamiltonian_energy;
    logic [NUM_ROW-1:0]    save_spin_array;
    logic [DATA_WIDTH-1:0] max_fails;
    logic                  cal_done, done_ack, done;
    logic [NUM_ROW-1:0]    best_spin;
    energy_t               best_hamiltonian;
    logic [NUM_ROW-1:0]    result_spin;
    energy_t               result_energy;
    logic                  result_vld, busy, err;

    solve_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .max_fails_cfg(max_fails_cfg),
        .num_trials(num_trials), .sample_req(sample_req), .sample_vld(sample_vld),
        .sample_spin(sample_spin), .sample_energy(sample_energy),
        .hamiltonian_energy(hamiltonian_energy), .save_spin_array(save_spin_array),
        .max_fails(max_fails), .cal_done(cal_done), .done_ack(done_ack), .done(done),
        .best_spin(best_spin), .best_hamiltonian(best_hamiltonian),
        .result_spin(result_spin), .result_energy(result_energy),
        .result_vld(result_vld), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_WIDTH-1:0] mf;
        logic [7:0]            nt;
        int                    need, hold;
        energy_t               e0, e1, e2;
        logic [NUM_ROW-1:0]    s0, s1, s2;
        bit                    exp_err;
        energy_t               exp_e;
        logic [NUM_ROW-1:0]    exp_s;
        int                    exp_cal, exp_ack_len;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // model configuration and observation counters
    int                 cmp_need = 1, cmp_hold = 1;
    energy_t            tr_e [3];
    logic [NUM_ROW-1:0] tr_sp [3];
    bit                 smp_en = 1, stray_req = 0;
    int                 smp_wait = 0, smp_n = 0;
    energy_t            smp_e_last;
    logic [NUM_ROW-1:0] smp_s_last;
    int cal_cnt, hold_cnt, trial_idx;
    int n_req, n_cal, n_ack, n_res, n_err, n_busy;
    int ack_run, max_ack_len, gap_cnt, last_gap;
    bit gap_on, prev_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_req = 0; n_cal = 0; n_ack = 0; n_res = 0; n_err = 0; n_busy = 0;
        ack_run = 0; max_ack_len = 0; gap_cnt = 0; last_gap = -1; gap_on = 0;
        cal_cnt = 0; hold_cnt = 0; trial_idx = 0;
    endtask

    function automatic vec_t mk(input int mf, input int nt, input int need, input int hold,
                                input int e0, input int e1, input int e2,
                                input int s0, input int s1, input int s2,
                                input bit xerr, input int xe, input int xs,
                                input int xcal, input int xack);
        vec_t v;
        v.mf = DATA_WIDTH'(mf); v.nt = 8'(nt); v.need = need; v.hold = hold;
        v.e0 = energy_t'(e0); v.e1 = energy_t'(e1); v.e2 = energy_t'(e2);
        v.s0 = NUM_ROW'(s0); v.s1 = NUM_ROW'(s1); v.s2 = NUM_ROW'(s2);
        v.exp_err = xerr; v.exp_e = energy_t'(xe); v.exp_s = NUM_ROW'(xs);
        v.exp_cal = xcal; v.exp_ack_len = xack;
        return v;
    endfunction

    // Sampler, comparator and monitor, all acting on the falling edge
    initial begin
        int ti;
        done = 1'b0; sample_vld = 1'b0; sample_spin = '0; sample_energy = '0;
        best_spin = '0; best_hamiltonian = '0; prev_ack = 1'b0;
        clr();
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                done = 1'b0; sample_vld = 1'b0; smp_wait = 0;
                cal_cnt = 0; hold_cnt = 0; prev_ack = 1'b0; ack_run = 0;
            end else begin
                sample_vld = 1'b0;
                if (stray_req) begin
                    sample_vld = 1'b1; sample_spin = 8'h77; sample_energy = energy_t'(123);
                    stray_req = 0;
                end
                if (smp_wait > 0) begin
                    smp_wait--;
                    if (smp_wait == 0 && smp_en) begin
                        smp_n++;
                        sample_vld    = 1'b1;
                        sample_energy = energy_t'(smp_n * 7 - 300);
                        sample_spin   = NUM_ROW'(smp_n * 13 + 1);
                        smp_e_last    = sample_energy;
                        smp_s_last    = sample_spin;
                    end
                end
                if (sample_req === 1'b1) begin n_req++; smp_wait = 2; end
                if (cal_done === 1'b1) begin
                    n_cal++;
                    chk("cal_energy", hamiltonian_energy, smp_e_last);
                    chk("cal_spin", save_spin_array, smp_s_last);
                end
                if (err === 1'b1) n_err++;
                if (result_vld === 1'b1) n_res++;
                if (busy === 1'b1) n_busy++;
                if (done) begin
                    if (done_ack === 1'b1) begin
                        hold_cnt++;
                        if (hold_cnt >= cmp_hold) begin done = 1'b0; hold_cnt = 0; trial_idx++; end
                    end
                end else if (cal_done === 1'b1) begin
                    cal_cnt++;
                    if (cal_cnt == cmp_need) begin
                        ti = (trial_idx > 2) ? 2 : trial_idx;
                        cal_cnt = 0; done = 1'b1;
                        best_hamiltonian = tr_e[ti]; best_spin = tr_sp[ti];
                    end
                end
                if (done_ack === 1'b1) begin
                    if (!prev_ack) n_ack++;
                    ack_run++;
                    if (ack_run > max_ack_len) max_ack_len = ack_run;
                end else begin
                    ack_run = 0;
                end
                if (prev_ack && done_ack !== 1'b1) begin gap_on = 1; gap_cnt = 0; end
                if (gap_on) begin
                    if (sample_req === 1'b1) begin last_gap = gap_cnt; gap_on = 0; end
                    else gap_cnt++;
                end
                prev_ack = (done_ack === 1'b1);
            end
        end
    end

    vec_t vecs [8];
    logic [DATA_WIDTH-1:0] exp_mf;

    initial begin
        int cyc;
        int k;
        vecs[0] = mk(3, 1, 3, 1,    -40, 0, 0,          'h5A, 0, 0,       0, -40, 'h5A, 3, 3);
        vecs[1] = mk(5, 3, 1, 1,    -10, -25, -25,      'hA1, 'hB2, 'hC3, 0, -25, 'hB2, 3, 3);
        vecs[2] = mk(0, 2, 1, 1,    0, 0, 0,            0, 0, 0,          1, -25, 'hB2, 0, 0);
        vecs[3] = mk(4, 0, 1, 1,    0, 0, 0,            0, 0, 0,          1, -25, 'hB2, 0, 0);
        vecs[4] = mk(2, 2, 2, 10,   100, 7, 0,          'h11, 'h22, 0,    0, 7, 'h22, 4, 10);
        vecs[5] = mk(255, 2, 1, 1,  -32768, -32768, 0,  'h3C, 'hC3, 0,    0, -32768, 'h3C, 2, 3);
        vecs[6] = mk(1, 3, 2, 1,    32767, -1, 0,       1, 2, 3,          0, -1, 2, 6, 3);
        vecs[7] = mk(9, 255, 1, 1,  20, 10, 30,         'h44, 'h55, 'h66, 0, 10, 'h55, 255, 3);

        reset = 1'b1; start = 1'b0; max_fails_cfg = '0; num_trials = '0;
        repeat (3) step();
        chk("rst_sample_req", sample_req, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_done_ack", done_ack, 0);
        chk("rst_result_vld", result_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ham", hamiltonian_energy, 0);
        chk("rst_spin", save_spin_array, 0);
        chk("rst_max_fails", max_fails, 0);
        chk("rst_result_spin", result_spin, 0);
        chk("rst_result_energy", result_energy, 0);
        reset = 1'b0;
        exp_mf = '0;
        repeat (2) step();

        // sample_vld while idle must not be captured
        clr();
        stray_req = 1;
        repeat (3) step();
        chk("stray_ham", hamiltonian_energy, 0);
        chk("stray_spin", save_spin_array, 0);
        chk("stray_cal", n_cal, 0);
        chk("stray_busy", n_busy, 0);

        for (int i = 0; i < 8; i++) begin
            clr();
            cmp_need = vecs[i].need; cmp_hold = vecs[i].hold;
            tr_e[0] = vecs[i].e0; tr_e[1] = vecs[i].e1; tr_e[2] = vecs[i].e2;
            tr_sp[0] = vecs[i].s0; tr_sp[1] = vecs[i].s1; tr_sp[2] = vecs[i].s2;
            start = 1'b1; max_fails_cfg = vecs[i].mf; num_trials = vecs[i].nt;
            step();
            start = 1'b0;
            if (!vecs[i].exp_err) exp_mf = vecs[i].mf;
            if (vecs[i].exp_err) begin
                repeat (8) step();
                chk($sformatf("v%0d_busy_cycles", i), n_busy, 0);
            end else begin
                cyc = 0;
                while (n_res == 0 && cyc < 10000) begin step(); cyc++; end
                chk($sformatf("v%0d_no_timeout", i), (cyc < 10000) ? 1 : 0, 1);
                repeat (3) step();
                chk($sformatf("v%0d_ack_len", i), max_ack_len, vecs[i].exp_ack_len);
                if (vecs[i].nt > 1) chk($sformatf("v%0d_release_gap", i), last_gap, 2);
            end
            chk($sformatf("v%0d_err", i), n_err, vecs[i].exp_err ? 1 : 0);
            chk($sformatf("v%0d_req", i), n_req, vecs[i].exp_cal);
            chk($sformatf("v%0d_cal", i), n_cal, vecs[i].exp_cal);
            chk($sformatf("v%0d_acks", i), n_ack, vecs[i].exp_err ? 0 : int'(vecs[i].nt));
            chk($sformatf("v%0d_result_vld", i), n_res, vecs[i].exp_err ? 0 : 1);
            chk($sformatf("v%0d_result_energy", i), result_energy, vecs[i].exp_e);
            chk($sformatf("v%0d_result_spin", i), result_spin, vecs[i].exp_s);
            chk($sformatf("v%0d_max_fails", i), max_fails, exp_mf);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
        end

        // a second start mid-solve is ignored
        clr();
        cmp_need = 1; cmp_hold = 1; tr_e[0] = energy_t'(-5); tr_sp[0] = 8'h99;
        start = 1'b1; max_fails_cfg = 8'd6; num_trials = 8'd1;
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1; max_fails_cfg = 8'd9; num_trials = 8'd5;
        step();
        start = 1'b0;
        cyc = 0;
        while (n_res == 0 && cyc < 1000) begin step(); cyc++; end
        repeat (3) step();
        chk("busy_start_max_fails", max_fails, 6);
        chk("busy_start_acks", n_ack, 1);
        chk("busy_start_results", n_res, 1);
        chk("busy_start_energy", result_energy, energy_t'(-5));

`ifdef SOLVE_TIMEOUT_EN
        clr();
        smp_en = 0;
        start = 1'b1; max_fails_cfg = 8'd1; num_trials = 8'd1;
        step();
        start = 1'b0;
        step();
        k = 0;
        while (err !== 1'b1 && k < 70000) begin step(); k++; end
        chk("wdog_cycles", k, 65535);
        step();
        chk("wdog_busy", busy, 0);
        chk("wdog_results", n_res, 0);
        smp_en = 1;
        repeat (3) step();
`endif

        // reset in the middle of the done handshake
        clr();
        cmp_need = 1; cmp_hold = 50; tr_e[0] = energy_t'(-9); tr_sp[0] = 8'h5;
        start = 1'b1; max_fails_cfg = 8'd2; num_trials = 8'd1;
        step();
        start = 1'b0;
        k = 0;
        while (done_ack !== 1'b1 && k < 200) begin step(); k++; end
        chk("rst_ack_reached", (k < 200) ? 1 : 0, 1);
        step();
        reset = 1'b1;
        step();
        chk("rst_ack_done_ack", done_ack, 0);
        chk("rst_ack_busy", busy, 0);
        reset = 1'b0;
        repeat (20) step();
        chk("rst_ack_results", n_res, 0);
        chk("rst_ack_result_energy", result_energy, 0);
        chk("rst_ack_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
